// File: rtl/snn_core_tdm_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_core_tdm_if
// Brief    : Step, spike and config bus of the time-multiplexed LIF core.
// Revision : 1.0
// ============================================================================
interface snn_core_tdm_if #(
    parameter int F = 48,
    parameter int N = 96
);
    localparam int AW = $clog2(F * N);

    logic          in_valid;
    logic          in_ready;
    logic [F-1:0]  in_events;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_spikes;
    logic          cfg_we;
    logic          cfg_sel;
    logic [AW-1:0] cfg_addr;
    logic [15:0]   cfg_wdata;
    logic          cfg_ready;
    logic [31:0]   step_cnt;

    modport slave (
        input  in_valid, in_events, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_spikes, cfg_ready, step_cnt
    );

    modport master (
        output in_valid, in_events, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_spikes, cfg_ready, step_cnt
    );
endinterface
`default_nettype wire

// File: rtl/snn_core_tdm.sv
`default_nettype none
// ============================================================================
// Module   : snn_core_tdm
// Brief    : Time-multiplexed Q1.14 LIF layer, one neuron evaluated at a time.
// Revision : 1.0
// ============================================================================
module snn_core_tdm #(
    parameter int               F          = 48,
    parameter int               N          = 96,
    parameter int               Q          = 14,
    parameter int               ALPHA_Q14  = 15474,
    parameter int               REFRAC     = 2,
    parameter int               RESET_MODE = 0,
    parameter logic signed [15:0] VRESET   = 16'sd0
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    snn_core_tdm_if.slave   bus
);

    localparam int AW = $clog2(F * N);
    localparam int FW = $clog2(F + 1);
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [31:0] c_ALPHA  = 32'(ALPHA_Q14);
    localparam logic signed [31:0] c_HALF   = 32'sd1 <<< (Q - 1);
    localparam logic [AW:0]        c_WDEPTH = (AW + 1)'(F * N);
    localparam logic [AW:0]        c_NDEPTH = (AW + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_UPD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Weight / threshold storage (never reset) and per-neuron state (reset)
    logic signed [15:0] r_wram   [F*N];
    logic signed [15:0] r_vram   [N];
    logic signed [15:0] r_v      [N];
    logic [7:0]         r_refrac [N];

    logic [F-1:0]       r_events;
    logic [F-1:0]       r_evsh;
    logic [FW-1:0]      r_f;
    logic [NW-1:0]      r_n;
    logic [AW-1:0]      r_raddr;
    logic signed [15:0] r_rdata;
    logic               r_rd_ev;
    logic signed [31:0] r_acc;
    logic [N-1:0]       r_spikes;
    logic [31:0]        r_step_cnt;

    logic               w_in_ready;
    logic               w_out_valid;

    function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
        if (x > 34'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Neuron update arithmetic, evaluated while in S_UPD
    // ------------------------------------------------------------------
    logic signed [15:0] w_v_cur;
    logic signed [15:0] w_vth;
    logic signed [31:0] w_vext;
    logic signed [31:0] w_leak;
    logic signed [31:0] w_bias;
    logic signed [31:0] w_rnd;
    logic signed [33:0] w_sum;
    logic signed [15:0] w_vnext;
    logic signed [33:0] w_diff;
    logic signed [15:0] w_vreset;
    logic               w_fire;

    assign w_v_cur  = r_v[r_n];
    assign w_vth    = r_vram[r_n];
    assign w_vext   = {{16{w_v_cur[15]}}, w_v_cur};
    assign w_leak   = c_ALPHA * w_vext;
    assign w_bias   = w_leak[31] ? -c_HALF : c_HALF;
    assign w_rnd    = (w_leak + w_bias) >>> Q;
    assign w_sum    = {{2{w_rnd[31]}}, w_rnd} + {{2{r_acc[31]}}, r_acc};
    assign w_vnext  = sat16(w_sum);
    assign w_diff   = {{18{w_vnext[15]}}, w_vnext} - {{18{w_vth[15]}}, w_vth};
    assign w_vreset = (RESET_MODE == 1) ? sat16(w_diff) : VRESET;
    assign w_fire   = (r_refrac[r_n] == 8'd0) && (w_vnext >= w_vth);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (r_f == FW'(F)) begin
                    w_state_nxt = S_UPD;
                end
            end
            S_UPD: begin
                w_state_nxt = (r_n == NW'(N - 1)) ? S_DONE : S_ACC;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.cfg_ready  = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_spikes = r_spikes;
    assign bus.step_cnt   = r_step_cnt;

    // ------------------------------------------------------------------
    // Config writes and synchronous weight read (1-cycle latency)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.cfg_we) begin
            if (!bus.cfg_sel && ({1'b0, bus.cfg_addr} < c_WDEPTH)) begin
                r_wram[bus.cfg_addr] <= $signed(bus.cfg_wdata);
            end
            if (bus.cfg_sel && ({1'b0, bus.cfg_addr} < c_NDEPTH)) begin
                r_vram[bus.cfg_addr[NW-1:0]] <= $signed(bus.cfg_wdata);
            end
        end
        r_rdata <= r_wram[r_raddr];
    end

    // ------------------------------------------------------------------
    // Datapath: r_f counts F read cycles plus one drain cycle per neuron;
    // the add in cycle f consumes the read issued in cycle f-1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_events   <= '0;
            r_evsh     <= '0;
            r_f        <= '0;
            r_n        <= '0;
            r_raddr    <= '0;
            r_rd_ev    <= 1'b0;
            r_acc      <= '0;
            r_spikes   <= '0;
            r_step_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_v[i]      <= '0;
                r_refrac[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_events <= bus.in_events;
                        r_evsh   <= bus.in_events;
                        r_f      <= '0;
                        r_n      <= '0;
                        r_acc    <= '0;
                        r_raddr  <= '0;
                    end
                end
                S_ACC: begin
                    r_f <= r_f + FW'(1);
                    if (r_f != '0 && r_rd_ev) begin
                        r_acc <= r_acc + {{16{r_rdata[15]}}, r_rdata};
                    end
                    if (r_f < FW'(F)) begin
                        r_rd_ev <= r_evsh[0];
                        r_evsh  <= r_evsh >> 1;
                        r_raddr <= r_raddr + AW'(N);
                    end
                end
                S_UPD: begin
                    r_spikes[r_n] <= w_fire;
                    if (w_fire) begin
                        r_v[r_n]      <= w_vreset;
                        r_refrac[r_n] <= 8'(REFRAC);
                    end else begin
                        r_v[r_n] <= w_vnext;
                        if (r_refrac[r_n] != 8'd0) begin
                            r_refrac[r_n] <= r_refrac[r_n] - 8'd1;
                        end
                    end
                    r_n     <= r_n + NW'(1);
                    r_f     <= '0;
                    r_acc   <= '0;
                    r_evsh  <= r_events;
                    r_raddr <= AW'(r_n) + AW'(1);
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_step_cnt <= r_step_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
